// File: rtl/ps2_host_tx_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | ps2_host_tx_pkg : states and command codes for the PS/2 host TX    |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package ps2_host_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_INHIBIT   = 3'd1,
        ST_REQ       = 3'd2,
        ST_DATA      = 3'd3,
        ST_PARITY    = 3'd4,
        ST_STOP      = 3'd5,
        ST_WAIT_IDLE = 3'd6
    } state_e;

    localparam logic [7:0] PS2_CMD_SET_LED = 8'hED;
    localparam logic [7:0] PS2_CMD_RESET   = 8'hFF;
    localparam logic [7:0] PS2_ACK_BYTE    = 8'hFA;

    // Odd parity across data plus parity bit
    function automatic logic odd_parity(input logic [7:0] d);
        return ~^d;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_host_tx_line_sync.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | ps2_host_tx_line_sync : synchronises ps2_clk/ps2_data, flags falls  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module ps2_host_tx_line_sync (
    input  logic clk,
    input  logic clrn,
    input  logic ps2_clk_i,
    input  logic ps2_data_i,
    output logic clk_s_o,
    output logic data_s_o,
    output logic clk_fall_o
);

    // Reset to 1 so an idle bus never produces a spurious fall after reset
    logic [2:0] clk_q;
    logic [1:0] data_q;

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            clk_q  <= 3'b111;
            data_q <= 2'b11;
        end else begin
            clk_q  <= {clk_q[1:0], ps2_clk_i};
            data_q <= {data_q[0], ps2_data_i};
        end
    end

    assign clk_s_o    = clk_q[1];
    assign data_s_o   = data_q[1];
    assign clk_fall_o = clk_q[2] & ~clk_q[1];

endmodule
`default_nettype wire

// File: rtl/ps2_host_tx.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | ps2_host_tx : PS/2 host-to-device command byte transmitter         |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module ps2_host_tx
    import ps2_host_tx_pkg::*;
#(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 750000
) (
    input  logic       clk,
    input  logic       clrn,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic       busy,
    output logic       done,
    output logic       ack_err,
    output logic       timeout
);

    localparam int INH_W = $clog2(INHIBIT_CYCLES + 1);
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    state_e           state_q, state_d;
    logic [INH_W-1:0] inh_q, inh_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic [3:0]       bit_q, bit_d;
    logic [8:0]       shift_q, shift_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic             tout_q, tout_d;

    logic clk_s, data_s, clk_fall;

    ps2_host_tx_line_sync u_sync (
        .clk        (clk),
        .clrn       (clrn),
        .ps2_clk_i  (ps2_clk_in),
        .ps2_data_i (ps2_data_in),
        .clk_s_o    (clk_s),
        .data_s_o   (data_s),
        .clk_fall_o (clk_fall)
    );

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_q <= ST_IDLE;
            inh_q   <= '0;
            tmo_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            tout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            inh_q   <= inh_d;
            tmo_q   <= tmo_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            done_q  <= done_d;
            err_q   <= err_d;
            tout_q  <= tout_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        inh_d       = inh_q;
        tmo_d       = tmo_q;
        bit_d       = bit_q;
        shift_d     = shift_q;
        done_d      = 1'b0;
        err_d       = 1'b0;
        tout_d      = 1'b0;
        ps2_clk_oe  = 1'b0;
        ps2_data_oe = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (tx_valid) begin
                    state_d = ST_INHIBIT;
                    inh_d   = '0;
                    shift_d = {odd_parity(tx_data), tx_data};
                end
            end
            ST_INHIBIT: begin
                ps2_clk_oe = 1'b1;
                if (inh_q == INH_LAST) begin
                    ps2_data_oe = 1'b1;
                    state_d     = ST_REQ;
                    tmo_d       = '0;
                end else begin
                    inh_d = inh_q + 1'b1;
                end
            end
            ST_REQ: begin
                ps2_data_oe = 1'b1;
                if (clk_fall) begin
                    state_d = ST_DATA;
                    bit_d   = '0;
                end
            end
            ST_DATA: begin
                ps2_data_oe = ~shift_q[0];
                if (clk_fall) begin
                    shift_d = shift_q >> 1;
                    if (bit_q == 4'd7) state_d = ST_PARITY;
                    else               bit_d   = bit_q + 1'b1;
                end
            end
            ST_PARITY: begin
                ps2_data_oe = ~shift_q[0];
                if (clk_fall) state_d = ST_STOP;
            end
            ST_STOP: begin
                if (clk_fall) begin
                    done_d  = ~data_s;
                    err_d   = data_s;
                    state_d = ST_WAIT_IDLE;
                end
            end
            ST_WAIT_IDLE: begin
                if (clk_s && data_s) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // Timeout overrides any bit progress, but an ACK on the same cycle wins
        if (state_q inside {ST_REQ, ST_DATA, ST_PARITY, ST_STOP}) begin
            if (tmo_q == TMO_LAST) begin
                if (!(state_q == ST_STOP && clk_fall)) begin
                    tout_d  = 1'b1;
                    state_d = ST_WAIT_IDLE;
                end
            end else begin
                tmo_d = tmo_q + 1'b1;
            end
        end
    end

    assign tx_ready = (state_q == ST_IDLE);
    assign busy     = (state_q != ST_IDLE);
    assign done     = done_q;
    assign ack_err  = err_q;
    assign timeout  = tout_q;

endmodule
`default_nettype wire

// File: tb/tb_ps2_host_tx.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_ps2_host_tx : directed bench with a simple keyboard-side model  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_ps2_host_tx;

    localparam int INH  = 20;
    localparam int TMO  = 200;
    localparam int HALF = 6;

    logic       clk = 1'b0;
    logic       clrn;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       ps2_clk_in, ps2_data_in;
    logic       ps2_clk_oe, ps2_data_oe;
    logic       busy, done, ack_err, timeout;
    logic       dev_clk, dev_data;

    int checks   = 0;
    int failures = 0;
    int n_done, n_err, n_tmo;

    logic [10:0] frame;
    int          inh_n, doe_n, req_n;
    logic        doe_last, rdy_bad;

    assign ps2_clk_in  = dev_clk  & ~ps2_clk_oe;
    assign ps2_data_in = dev_data & ~ps2_data_oe;

    always #5 clk = ~clk;

    ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO)) dut (
        .clk         (clk),
        .clrn        (clrn),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .ps2_clk_in  (ps2_clk_in),
        .ps2_data_in (ps2_data_in),
        .ps2_clk_oe  (ps2_clk_oe),
        .ps2_data_oe (ps2_data_oe),
        .busy        (busy),
        .done        (done),
        .ack_err     (ack_err),
        .timeout     (timeout)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        if (done)    n_done++;
        if (ack_err) n_err++;
        if (timeout) n_tmo++;
    endtask

    task automatic clear_counts();
        n_done = 0; n_err = 0; n_tmo = 0;
    endtask

    task automatic start_tx(input logic [7:0] b);
        tx_data  = b;
        tx_valid = 1'b1;
        tick();
        tx_valid = 1'b0;
        tx_data  = ~b;
    endtask

    task automatic inhibit_phase();
        inh_n = 0; doe_n = 0; doe_last = 1'b0; rdy_bad = 1'b0;
        while (ps2_clk_oe && inh_n < 1000) begin
            inh_n++;
            if (ps2_data_oe) doe_n++;
            doe_last = ps2_data_oe;
            if (tx_ready) rdy_bad = 1'b1;
            tick();
        end
    endtask

    // Keyboard side: clocks the frame, samples on rising edges, optional ACK
    task automatic device_frame(input bit ack, input int nfalls);
        frame = '1;
        repeat (4) tick();
        frame[0] = ps2_data_in;
        for (int i = 1; i <= nfalls; i++) begin
            dev_clk = 1'b0;
            repeat (HALF) tick();
            if (i == nfalls && nfalls < 11) return;
            dev_clk = 1'b1;
            if (i <= 10) frame[i] = ps2_data_in;
            if (i == 10 && ack) dev_data = 1'b0;
            repeat (HALF) tick();
        end
        dev_data = 1'b1;
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 300 && busy; k++) tick();
        repeat (2) tick();
    endtask

    task automatic full_send(input logic [7:0] b, input bit ack);
        clear_counts();
        start_tx(b);
        inhibit_phase();
        device_frame(ack, 11);
        wait_idle();
    endtask

    initial begin
        clrn = 1'b0; tx_valid = 1'b0; tx_data = 8'h00;
        dev_clk = 1'b1; dev_data = 1'b1;
        clear_counts();
        repeat (3) @(negedge clk);
        check("rst_tx_ready", tx_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_clk_oe", ps2_clk_oe, 0);
        check("rst_data_oe", ps2_data_oe, 0);
        check("rst_done", done, 0);
        check("rst_ack_err", ack_err, 0);
        check("rst_timeout", timeout, 0);
        clrn = 1'b1;
        repeat (4) tick();

        // 0xED: inhibit timing, frame, ACK
        clear_counts();
        start_tx(8'hED);
        inhibit_phase();
        check("inh_cycles", inh_n, INH);
        check("inh_data_oe_cycles", doe_n, 1);
        check("inh_data_oe_last", doe_last, 1);
        check("inh_tx_ready_low", rdy_bad, 0);
        device_frame(1'b1, 11);
        wait_idle();
        check("ed_frame", frame, {1'b1, 1'b1, 8'hED, 1'b0});
        check("ed_done", n_done, 1);
        check("ed_ack_err", n_err, 0);
        check("ed_timeout", n_tmo, 0);
        check("ed_busy_after", busy, 0);
        check("ed_ready_after", tx_ready, 1);

        full_send(8'h01, 1'b1);
        check("x01_frame", frame, {1'b1, 1'b0, 8'h01, 1'b0});
        check("x01_done", n_done, 1);

        full_send(8'hFF, 1'b1);
        check("xff_frame", frame, {1'b1, 1'b1, 8'hFF, 1'b0});
        check("xff_done", n_done, 1);

        // Missing ACK
        full_send(8'hED, 1'b0);
        check("noack_err", n_err, 1);
        check("noack_done", n_done, 0);
        check("noack_tmo", n_tmo, 0);
        check("noack_clk_oe", ps2_clk_oe, 0);
        check("noack_data_oe", ps2_data_oe, 0);

        // Device never clocks
        clear_counts();
        start_tx(8'hFF);
        inhibit_phase();
        req_n = 0;
        while (ps2_data_oe && req_n < 1000) begin
            req_n++;
            tick();
        end
        check("tmo_req_cycles", req_n, TMO);
        check("tmo_pulse_now", timeout, 1);
        check("tmo_clk_oe", ps2_clk_oe, 0);
        check("tmo_data_oe", ps2_data_oe, 0);
        wait_idle();
        check("tmo_count", n_tmo, 1);
        check("tmo_done", n_done, 0);

        // Reset while bit 4 is on the line
        clear_counts();
        start_tx(8'hED);
        inhibit_phase();
        device_frame(1'b1, 5);
        check("mid_busy", busy, 1);
        check("mid_bit4", ps2_data_oe, 1);
        clrn = 1'b0;
        #1;
        check("mid_rst_clk_oe", ps2_clk_oe, 0);
        check("mid_rst_data_oe", ps2_data_oe, 0);
        check("mid_rst_busy", busy, 0);
        dev_clk = 1'b1;
        repeat (2) tick();
        clrn = 1'b1;
        repeat (4) tick();
        check("mid_no_pulses", n_done + n_err + n_tmo, 0);
        full_send(8'hFF, 1'b1);
        check("post_rst_frame", frame, {1'b1, 1'b1, 8'hFF, 1'b0});
        check("post_rst_done", n_done, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
